// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers of the RV32IM core:
// stage register state encoding, default boundary widths and a state helper.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  // Default payload/control widths for each pipeline boundary.
  localparam int IF_ID_W      = 64;
  localparam int ID_EX_DATA_W = 96;
  localparam int ID_EX_CTRL_W = 24;
  localparam int EX_MEM_W     = 72;
  localparam int MEM_WB_W     = 40;

  function automatic logic [1:0] state_occupancy(input pipe_state_e st);
    logic [1:0] occ;
    occ = 2'd0;
    case (st)
      ST_EMPTY: occ = 2'd0;
      ST_FULL:  occ = 2'd1;
      ST_SKID:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a pipeline stage: payload plus control bundle, with a
// load enable and a synchronous clear that zeroes only the control bundle.
module pipe_slot #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  // Payload is never cleared outside reset; the control bundle alone marks a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      ctrl_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
      ctrl_q <= ctrl_i;
    end else if (clr_i) begin
      ctrl_q <= '0;
    end
  end

  assign data_o = data_q;
  assign ctrl_o = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with stall, flush-to-bubble and an
// optional two-entry skid buffer that makes in_ready independent of out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = ID_EX_DATA_W,
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  // Handshake: an entry moves upstream->stage when in_valid & in_ready, and
  // stage->downstream when out_valid & out_ready & !stall, at the rising edge.

  pipe_state_e state_q, state_d;

  logic accept;
  logic emit;
  logic main_load;
  logic main_from_skid;
  logic main_clr;
  logic skid_load;
  logic skid_clr;

  logic [DATA_W-1:0] main_data_in;
  logic [CTRL_W-1:0] main_ctrl_in;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_occupancy(state_q);

  always_comb begin
    in_ready = !rst && !stall && !flush;
    if (SKID) begin
      in_ready = in_ready && (state_q != ST_SKID);
    end else begin
      in_ready = in_ready && (!out_valid || out_ready);
    end
  end

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready && !stall;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clr       = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept && emit) begin
            main_load = 1'b1;
          end else if (accept && SKID) begin
            skid_load = 1'b1;
            state_d   = ST_SKID;
          end else if (emit) begin
            main_clr = 1'b1;
            state_d  = ST_EMPTY;
          end
        end
        ST_SKID: begin
          // in_ready is low here, so the only move is skid -> main on emit.
          if (emit) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = ST_FULL;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign main_data_in = main_from_skid ? skid_data : in_data;
  assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;

  pipe_slot #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .load_i (main_load),
    .clr_i  (main_clr),
    .data_i (main_data_in),
    .ctrl_i (main_ctrl_in),
    .data_o (out_data),
    .ctrl_o (out_ctrl)
  );

  generate
    if (SKID) begin : g_skid
      pipe_slot #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W)
      ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load_i (skid_load),
        .clr_i  (skid_clr),
        .data_i (in_data),
        .ctrl_i (in_ctrl),
        .data_o (skid_data),
        .ctrl_o (skid_ctrl)
      );
    end else begin : g_no_skid
      logic unused_skid;
      assign skid_data   = '0;
      assign skid_ctrl   = '0;
      assign unused_skid = skid_load ^ skid_clr;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid (index 1) and one non-skid (index 0) instance,
// each checked every cycle against a queue-of-held-entries reference model.
module tb_pipe_stage_reg;

  localparam int DW = 96;
  localparam int CW = 24;
  localparam int EW = DW + CW;

  typedef logic [EW-1:0] ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_v       [2];
  logic          stall_v     [2];
  logic          flush_v     [2];
  logic          in_valid_v  [2];
  logic          in_ready_v  [2];
  logic [DW-1:0] in_data_v   [2];
  logic [CW-1:0] in_ctrl_v   [2];
  logic          out_valid_v [2];
  logic          out_ready_v [2];
  logic [DW-1:0] out_data_v  [2];
  logic [CW-1:0] out_ctrl_v  [2];
  logic [1:0]    occ_v       [2];

  ent_t          exp_q0[$];
  ent_t          exp_q1[$];
  logic [DW-1:0] last_v [2];
  int            n_vec = 0;
  int            n_err = 0;
  bit            mon_en = 1'b0;
  bit            saw_c = 1'b0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) dut_noskid (
    .clk(clk), .rst(rst_v[0]), .stall(stall_v[0]), .flush(flush_v[0]),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_data(in_data_v[0]), .in_ctrl(in_ctrl_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .out_data(out_data_v[0]), .out_ctrl(out_ctrl_v[0]), .occupancy(occ_v[0])
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) dut_skid (
    .clk(clk), .rst(rst_v[1]), .stall(stall_v[1]), .flush(flush_v[1]),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_data(in_data_v[1]), .in_ctrl(in_ctrl_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .out_data(out_data_v[1]), .out_ctrl(out_ctrl_v[1]), .occupancy(occ_v[1])
  );

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: the stage is a FIFO of at most 2 (skid) entries; outputs show its head.
  function automatic void monitor(input int k, ref ent_t q[$]);
    int    n;
    bit    er;
    bit    em;
    bit    acc;
    ent_t  e;
    string t;
    t  = (k == 1) ? "skid" : "noskid";
    n  = q.size();
    er = !rst_v[k] && !stall_v[k] && !flush_v[k] &&
         ((k == 1) ? (n < 2) : (n == 0 || out_ready_v[k]));
    chk({t, ".occupancy"}, 128'(occ_v[k]), 128'(n));
    chk({t, ".out_valid"}, 128'(out_valid_v[k]), 128'(n > 0));
    chk({t, ".in_ready"}, 128'(in_ready_v[k]), 128'(er));
    if (n > 0) begin
      e = q[0];
      chk({t, ".out_entry"}, 128'({out_ctrl_v[k], out_data_v[k]}), 128'(e));
      last_v[k] = e[DW-1:0];
    end else begin
      chk({t, ".bubble_ctrl"}, 128'(out_ctrl_v[k]), 128'(0));
      chk({t, ".held_data"}, 128'(out_data_v[k]), 128'(last_v[k]));
    end
    if (k == 1 && out_valid_v[k] && out_ready_v[k] && !stall_v[k] && out_data_v[k] == DW'(32'hC))
      saw_c = 1'b1;
    if (rst_v[k]) begin
      q.delete();
      last_v[k] = '0;
    end else if (flush_v[k]) begin
      q.delete();
    end else if (!stall_v[k]) begin
      em  = (n > 0) && out_ready_v[k];
      acc = in_valid_v[k] && er;
      if (em) void'(q.pop_front());
      if (acc) q.push_back({in_ctrl_v[k], in_data_v[k]});
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      monitor(0, exp_q0);
      monitor(1, exp_q1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int k, input logic [DW-1:0] d);
    in_valid_v[k] = 1'b1;
    in_data_v[k]  = d;
    in_ctrl_v[k]  = CW'($urandom) | CW'(1);
  endtask

  task automatic idle(input int k);
    rst_v[k]       = 1'b0;
    stall_v[k]     = 1'b0;
    flush_v[k]     = 1'b0;
    in_valid_v[k]  = 1'b0;
    out_ready_v[k] = 1'b1;
  endtask

  task automatic rand_drive(input int k, input bit toggle_ready, input int cyc);
    rst_v[k]       = ($urandom_range(0, 199) == 0);
    flush_v[k]     = ($urandom_range(0, 39) == 0);
    stall_v[k]     = ($urandom_range(0, 5) == 0);
    in_valid_v[k]  = ($urandom_range(0, 3) != 0);
    in_data_v[k]   = {$urandom, $urandom, $urandom};
    in_ctrl_v[k]   = CW'($urandom) | CW'(1);
    out_ready_v[k] = toggle_ready ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      idle(k);
      rst_v[k]     = 1'b1;
      in_data_v[k] = '0;
      in_ctrl_v[k] = '0;
      last_v[k]    = '0;
    end
    step();
    step();
    mon_en = 1'b1;
    step();
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;

    // Streaming 0x10..0x17 with downstream always ready.
    for (int i = 0; i < 8; i++) begin
      put(1, DW'(32'h10 + i));
      step();
    end
    in_valid_v[1] = 1'b0;
    repeat (3) step();

    // Backpressure: fill both slots, then release.
    out_ready_v[1] = 1'b0;
    put(1, DW'(32'hA)); step();
    put(1, DW'(32'hB)); step();
    put(1, DW'(32'hD)); step();
    step();
    out_ready_v[1] = 1'b1;
    step();
    step();
    in_valid_v[1] = 1'b0;
    repeat (3) step();

    // Stall for three cycles in the middle of a stream.
    for (int i = 0; i < 7; i++) begin
      stall_v[1] = (i >= 2 && i < 5);
      put(1, DW'(32'h20 + i));
      step();
    end
    stall_v[1] = 1'b0;
    in_valid_v[1] = 1'b0;
    repeat (3) step();

    // Flush with two held entries while 0xC is offered.
    out_ready_v[1] = 1'b0;
    put(1, DW'(32'h30)); step();
    put(1, DW'(32'h31)); step();
    flush_v[1] = 1'b1;
    put(1, DW'(32'hC)); step();
    flush_v[1] = 1'b0;
    in_valid_v[1] = 1'b0;
    out_ready_v[1] = 1'b1;
    repeat (3) step();

    // Flush arriving while stalled.
    out_ready_v[1] = 1'b0;
    put(1, DW'(32'h40)); step();
    in_valid_v[1] = 1'b0;
    stall_v[1] = 1'b1;
    step();
    flush_v[1] = 1'b1;
    step();
    idle(1);
    repeat (2) step();

    // Reset while both slots are occupied.
    out_ready_v[1] = 1'b0;
    put(1, DW'(32'h50)); step();
    put(1, DW'(32'h51)); step();
    in_valid_v[1] = 1'b0;
    rst_v[1] = 1'b1;
    step();
    idle(1);
    repeat (2) step();

    chk("flushed_entry_never_emitted", 128'(saw_c), 128'(0));

    // Non-skid stage with out_ready toggling every cycle, no control events.
    for (int i = 0; i < 200; i++) begin
      in_valid_v[0]  = ($urandom_range(0, 3) != 0);
      in_data_v[0]   = {$urandom, $urandom, $urandom};
      in_ctrl_v[0]   = CW'($urandom) | CW'(1);
      out_ready_v[0] = (i % 2 == 0);
      rand_drive(1, 1'b0, i);
      step();
    end

    // Fully random traffic on both stages.
    for (int i = 0; i < 2000; i++) begin
      rand_drive(0, 1'b0, i);
      rand_drive(1, 1'b0, i);
      step();
    end
    idle(0);
    idle(1);
    repeat (4) step();
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
